// File: rtl/ibex_cheri_alu_sched.sv
// Arbitrates the shared EX-stage ALU adder between the integer/multdiv path and the CHERI ALU,
// sequencing multi-pass CHERI operations and handing their completion to writeback.
module ibex_cheri_alu_sched #(
    parameter int unsigned MaxPasses = 4,
    parameter int unsigned PassCntW  = $clog2(MaxPasses + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cheri_req_i,
    input  logic [PassCntW-1:0] cheri_num_passes_i,
    input  logic                int_alu_req_i,
    input  logic                kill_i,
    input  logic                ex_ready_i,
    input  logic [32:0]         alu_result_i,
    output logic                cheri_ack_o,
    output logic                cheri_grant_o,
    output logic [PassCntW-1:0] cheri_pass_idx_o,
    output logic [32:0]         prev_result_o,
    output logic                int_stall_o,
    output logic                cheri_busy_o,
    output logic                cheri_done_o,
    output logic                cheri_err_o
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [PassCntW-1:0] MaxPassesW = PassCntW'(MaxPasses);
    localparam logic [PassCntW-1:0] OnePass    = PassCntW'(1);

    state_e              state_q, state_d;
    logic [PassCntW-1:0] passes_q, passes_d;
    logic [PassCntW-1:0] pass_idx_q, pass_idx_d;
    logic [32:0]         prev_result_q, prev_result_d;
    logic                err_q, err_d;

    logic [PassCntW-1:0] req_passes;
    logic                req_err;
    logic                accept;

    // A zero count still needs one adder pass; oversize counts saturate and flag an error.
    always_comb begin
        req_passes = cheri_num_passes_i;
        req_err    = 1'b0;
        if (cheri_num_passes_i == '0) begin
            req_passes = OnePass;
        end else if (cheri_num_passes_i > MaxPassesW) begin
            req_passes = MaxPassesW;
            req_err    = 1'b1;
        end
    end

    // The integer path wins any same-cycle contention while idle.
    assign accept = (state_q == StIdle) & cheri_req_i & ~int_alu_req_i & ~kill_i;

    always_comb begin
        state_d       = state_q;
        passes_d      = passes_q;
        pass_idx_d    = pass_idx_q;
        prev_result_d = prev_result_q;
        err_d         = err_q;
        cheri_ack_o   = 1'b0;
        cheri_grant_o = 1'b0;
        int_stall_o   = 1'b0;
        cheri_done_o  = 1'b0;
        cheri_err_o   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cheri_ack_o = 1'b1;
                    passes_d    = req_passes;
                    err_d       = req_err;
                    pass_idx_d  = '0;
                    state_d     = StRun;
                end
            end
            StRun: begin
                cheri_grant_o = 1'b1;
                int_stall_o   = int_alu_req_i;
                prev_result_d = alu_result_i;
                if (pass_idx_q == passes_q - OnePass) begin
                    state_d = StDone;
                end else begin
                    pass_idx_d = pass_idx_q + OnePass;
                end
            end
            StDone: begin
                cheri_done_o = 1'b1;
                cheri_err_o  = err_q;
                if (ex_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (kill_i) begin
            state_d       = StIdle;
            pass_idx_d    = '0;
            prev_result_d = '0;
            err_d         = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            passes_q      <= '0;
            pass_idx_q    <= '0;
            prev_result_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            passes_q      <= passes_d;
            pass_idx_q    <= pass_idx_d;
            prev_result_q <= prev_result_d;
            err_q         <= err_d;
        end
    end

    assign cheri_pass_idx_o = pass_idx_q;
    assign prev_result_o    = prev_result_q;
    assign cheri_busy_o     = (state_q != StIdle);

    a_grant_only_in_run : assert property (
        @(posedge clk_i) disable iff (!rst_ni) cheri_grant_o |-> (state_q == StRun));
    a_stall_only_in_run : assert property (
        @(posedge clk_i) disable iff (!rst_ni) int_stall_o |-> (state_q == StRun));
    a_run_passes_legal : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (state_q == StRun) |-> (passes_q != '0 && passes_q <= MaxPassesW));

endmodule
